// File: rtl/temp_avg_pkg.sv
// Shared constants, state type and the average/round/clamp helper for temp_moving_avg.
// Build option: define TEMP_AVG_ROUND_EN for round-half-up averaging (default truncates).
package temp_avg_pkg;

    localparam int DATA_W      = 12;
    localparam int AVG_LOG2    = 3;
    localparam int MAX_DISPLAY = 2999;
    localparam int SUM_W       = DATA_W + AVG_LOG2;
    localparam int N           = 1 << AVG_LOG2;

    typedef enum logic [1:0] {
        CLR  = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // One extra bit keeps the rounding add from wrapping on a full-scale window.
    function automatic logic [DATA_W-1:0] avg_of_sum(input logic [SUM_W-1:0] sum);
        logic [SUM_W:0] t;
`ifdef TEMP_AVG_ROUND_EN
        t = {1'b0, sum} + (SUM_W+1)'(1 << (AVG_LOG2 - 1));
`else
        t = {1'b0, sum};
`endif
        t = t >> AVG_LOG2;
        if (t > (SUM_W+1)'(MAX_DISPLAY)) begin
            return DATA_W'(MAX_DISPLAY);
        end else begin
            return t[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/temp_moving_avg_if.sv
// Sample handshake, flush and average outputs of the temperature moving-average filter.
interface temp_moving_avg_if;
    import temp_avg_pkg::*;

    logic              clear;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              filling;

    modport master (
        output clear, sample_in, sample_valid,
        input  sample_ready, avg_out, avg_valid, filling
    );

    modport slave (
        input  clear, sample_in, sample_valid,
        output sample_ready, avg_out, avg_valid, filling
    );

endinterface

// File: rtl/temp_sample_ring.sv
// N-entry sample window; oldest_o is the entry the next write will overwrite.
module temp_sample_ring
    import temp_avg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ptr_rst_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] oldest_o
);

    logic [DATA_W-1:0]   mem_q [N];
    logic [AVG_LOG2-1:0] ptr_q;

    // Storage and write pointer; the pointer wraps naturally modulo N.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ptr_rst_i) begin
            ptr_q <= '0;
        end else if (we_i) begin
            mem_q[ptr_q] <= wdata_i;
            ptr_q        <= ptr_q + AVG_LOG2'(1);
        end else begin
            ptr_q <= ptr_q;
        end
    end

    assign oldest_o = mem_q[ptr_q];

endmodule

// File: rtl/temp_moving_avg.sv
// Moving-average filter: CLR/FILL/RUN control, running window sum, clamped average output.
// Rounding mode follows TEMP_AVG_ROUND_EN (see temp_avg_pkg).
module temp_moving_avg
    import temp_avg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    temp_moving_avg_if.slave   bus
);

    localparam logic [AVG_LOG2-1:0] LAST = AVG_LOG2'(N - 1);

    state_t              state_q, state_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic                ready_q, filling_q;
    logic                accept_s, ring_we_s, ptr_rst_s;
    logic [DATA_W-1:0]   ring_wdata_s, oldest_s;
    logic                acc_q, upd_q, avg_valid_q;
    logic [DATA_W-1:0]   new_q, old_q, avg_q;
    logic [SUM_W-1:0]    sum_q;

    temp_sample_ring u_ring (
        .clk       (clk),
        .rst       (rst),
        .ptr_rst_i (ptr_rst_s),
        .we_i      (ring_we_s),
        .wdata_i   (ring_wdata_s),
        .oldest_o  (oldest_s)
    );

    // Next state; CLR reuses the ring write path to zero one entry per cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ring_we_s    = 1'b0;
        ring_wdata_s = '0;
        ptr_rst_s    = 1'b0;
        accept_s     = bus.sample_valid && ready_q && !bus.clear;
        if (bus.clear) begin
            state_d   = CLR;
            cnt_d     = '0;
            ptr_rst_s = 1'b1;
        end else begin
            case (state_q)
                CLR: begin
                    ring_we_s = 1'b1;
                    cnt_d     = cnt_q + AVG_LOG2'(1);
                    if (cnt_q == LAST) begin
                        state_d = FILL;
                    end else begin
                        state_d = CLR;
                    end
                end
                FILL: begin
                    if (accept_s) begin
                        ring_we_s    = 1'b1;
                        ring_wdata_s = bus.sample_in;
                        cnt_d        = cnt_q + AVG_LOG2'(1);
                        state_d      = (cnt_q == LAST) ? RUN : FILL;
                    end else begin
                        state_d = FILL;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        ring_we_s    = 1'b1;
                        ring_wdata_s = bus.sample_in;
                    end else begin
                        ring_we_s = 1'b0;
                    end
                end
                default: begin
                    state_d   = CLR;
                    cnt_d     = '0;
                    ptr_rst_s = 1'b1;
                end
            endcase
        end
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLR;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            filling_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= (state_d != CLR);
            filling_q <= (state_d != RUN);
        end
    end

    // Accept -> sum -> average pipeline; clear flushes it but holds avg_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= 1'b0;
            new_q       <= '0;
            old_q       <= '0;
            sum_q       <= '0;
            upd_q       <= 1'b0;
            avg_valid_q <= 1'b0;
            avg_q       <= '0;
        end else if (bus.clear) begin
            acc_q       <= 1'b0;
            sum_q       <= '0;
            upd_q       <= 1'b0;
            avg_valid_q <= 1'b0;
        end else begin
            acc_q       <= accept_s;
            new_q       <= bus.sample_in;
            old_q       <= oldest_s;
            upd_q       <= acc_q;
            avg_valid_q <= upd_q;
            if (acc_q) begin
                sum_q <= sum_q + SUM_W'(new_q) - SUM_W'(old_q);
            end else begin
                sum_q <= sum_q;
            end
            if (upd_q) begin
                avg_q <= avg_of_sum(sum_q);
            end else begin
                avg_q <= avg_q;
            end
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.filling      = filling_q;
    assign bus.avg_out      = avg_q;
    assign bus.avg_valid    = avg_valid_q;

endmodule
